// File: rtl/uart_baud_ctrl.sv
// Runtime-programmable UART baud tick generator: oversampling tick, per-bit tick,
// divisor updates deferred to a bit boundary, and start-edge phase resync.
module uart_baud_ctrl #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned DEFAULT_BAUD = 19200,
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned NB_DIV       = 16
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_cfg_valid,
    input  logic [NB_DIV-1:0] i_cfg_div,
    output logic              o_cfg_ready,
    output logic              o_cfg_err,
    input  logic              i_resync,
    output logic              o_tick,
    output logic              o_bit_tick,
    output logic [NB_DIV-1:0] o_div
);

    localparam int unsigned OC_W = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;
    localparam logic [NB_DIV-1:0] DIV_RST = NB_DIV'(CLK_FREQ / DEFAULT_BAUD / OVERSAMPLING);
    localparam logic [OC_W-1:0]   OC_MAX  = OC_W'(OVERSAMPLING - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NB_DIV-1:0] div_q, div_d;
    logic [NB_DIV-1:0] shd_q, shd_d;
    logic [NB_DIV-1:0] cc_q, cc_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic              err_q, err_d;

    logic cc_last, oc_last, accept, cfg_legal, resync_c, tick_c, bit_tick_c;

    // Tick decode; a resync only counts while enabled and running
    always_comb begin
        cc_last    = (cc_q == (div_q - NB_DIV'(1)));
        oc_last    = (oc_q == OC_MAX);
        accept     = i_cfg_valid && (state_q != ST_PEND);
        cfg_legal  = (i_cfg_div >= NB_DIV'(2));
        resync_c   = i_enable && i_resync && (state_q != ST_OFF);
        tick_c     = (state_q != ST_OFF) && cc_last && !resync_c;
        bit_tick_c = tick_c && oc_last;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_OFF;
            div_q   <= DIV_RST;
            shd_q   <= DIV_RST;
            cc_q    <= '0;
            oc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            shd_q   <= shd_d;
            cc_q    <= cc_d;
            oc_q    <= oc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        shd_d   = shd_q;
        cc_d    = cc_q;
        oc_d    = oc_q;
        err_d   = accept && !cfg_legal;

        case (state_q)
            ST_OFF: begin
                cc_d = '0;
                oc_d = '0;
                if (accept && cfg_legal) begin
                    div_d = i_cfg_div;
                end
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_PEND: begin
                if (!i_enable) begin
                    // Stopping never discards an update, pending or just offered
                    state_d = ST_OFF;
                    cc_d    = '0;
                    oc_d    = '0;
                    if (state_q == ST_PEND) begin
                        div_d = shd_q;
                    end else if (accept && cfg_legal) begin
                        div_d = i_cfg_div;
                    end
                end else begin
                    if (resync_c) begin
                        cc_d = '0;
                        oc_d = '0;
                    end else if (cc_last) begin
                        cc_d = '0;
                        oc_d = oc_last ? '0 : oc_q + OC_W'(1);
                    end else begin
                        cc_d = cc_q + NB_DIV'(1);
                    end

                    if (state_q == ST_PEND) begin
                        if (bit_tick_c) begin
                            div_d   = shd_q;
                            state_d = ST_RUN;
                        end
                    end else if (accept && cfg_legal) begin
                        shd_d   = i_cfg_div;
                        state_d = ST_PEND;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                cc_d    = '0;
                oc_d    = '0;
            end
        endcase
    end

    assign o_tick      = tick_c;
    assign o_bit_tick  = bit_tick_c;
    assign o_cfg_ready = (state_q != ST_PEND);
    assign o_cfg_err   = err_q;
    assign o_div       = div_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: a phase-count reference model predicts every
// cycle's outputs; a negedge monitor pops and compares.
module tb_uart_baud_ctrl;

    localparam int unsigned OS  = 16;
    localparam int unsigned NB  = 16;
    localparam int          DEF = 162;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_enable;
    logic          i_cfg_valid;
    logic [NB-1:0] i_cfg_div;
    logic          o_cfg_ready;
    logic          o_cfg_err;
    logic          i_resync;
    logic          o_tick;
    logic          o_bit_tick;
    logic [NB-1:0] o_div;

    uart_baud_ctrl #(
        .CLK_FREQ    (50_000_000),
        .DEFAULT_BAUD(19200),
        .OVERSAMPLING(OS),
        .NB_DIV      (NB)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_div  (i_cfg_div),
        .o_cfg_ready(o_cfg_ready),
        .o_cfg_err  (o_cfg_err),
        .i_resync   (i_resync),
        .o_tick     (o_tick),
        .o_bit_tick (o_bit_tick),
        .o_div      (o_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tick;
        bit bit_tick;
        bit err;
        bit ready;
        int div;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: t counts cycles since the current phase origin
    bit m_en, m_pend, m_err;
    int m_div, m_shd, m_t;

    function automatic void check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_en = 0; m_pend = 0; m_err = 0;
        m_div = DEF; m_shd = DEF; m_t = 0;
    endfunction

    function automatic void model_step(input bit en, input bit rs, input bit v, input int d);
        exp_t e;
        bit   accept, legal;
        e.ready    = !m_pend;
        e.tick     = m_en && ((m_t % m_div) == m_div - 1) && !(en && rs);
        e.bit_tick = e.tick && ((m_t % (OS * m_div)) == OS * m_div - 1);
        e.err      = m_err;
        e.div      = m_div;
        q.push_back(e);

        accept = v && !m_pend;
        legal  = d >= 2;
        m_err  = accept && !legal;
        if (!m_en) begin
            if (accept && legal) m_div = d;
            if (en) begin m_en = 1; m_t = 0; end
        end else if (!en) begin
            m_en = 0;
            if (m_pend) begin m_div = m_shd; m_pend = 0; end
            else if (accept && legal) m_div = d;
        end else begin
            m_t = rs ? 0 : m_t + 1;
            if (m_pend) begin
                if (e.bit_tick) begin m_div = m_shd; m_pend = 0; m_t = 0; end
            end else if (accept && legal) begin
                m_shd = d; m_pend = 1;
            end
        end
    endfunction

    task automatic cycle(input bit en, input bit rs, input bit v, input int d);
        @(posedge clk);
        #1;
        i_enable    = en;
        i_resync    = rs;
        i_cfg_valid = v;
        i_cfg_div   = NB'(d);
        model_step(en, rs, v, d);
    endtask

    // Idle-run until the model's upcoming cycle sits at phase pos within a tick (0) or bit (1)
    task automatic wait_phase(input bit per_bit, input int pos);
        bit found = 0;
        for (int n = 0; n < 20000; n++) begin
            if (m_en && ((m_t % (per_bit ? OS * m_div : m_div)) == pos)) begin
                found = 1;
                break;
            end
            cycle(1, 0, 0, 0);
        end
        check("wait_phase_found", int'(found), 1);
    endtask

    always @(negedge clk) begin
        if (i_rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("o_tick",      int'(o_tick),      int'(e.tick));
            check("o_bit_tick",  int'(o_bit_tick),  int'(e.bit_tick));
            check("o_cfg_err",   int'(o_cfg_err),   int'(e.err));
            check("o_cfg_ready", int'(o_cfg_ready), int'(e.ready));
            check("o_div",       int'(o_div),       e.div);
        end
    end

    initial begin
        bit en_r;
        i_rst_n = 1'b0; i_enable = 1'b0; i_resync = 1'b0;
        i_cfg_valid = 1'b0; i_cfg_div = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick",  int'(o_tick), 0);
        check("rst_bit",   int'(o_bit_tick), 0);
        check("rst_err",   int'(o_cfg_err), 0);
        check("rst_ready", int'(o_cfg_ready), 1);
        check("rst_div",   int'(o_div), DEF);
        i_rst_n = 1'b1;

        // Default divisor: two full bits
        repeat (2 * OS * DEF + 20) cycle(1, 0, 0, 0);

        // Load div=4 while stopped, then run
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 4);
        cycle(0, 0, 0, 0);
        repeat (200) cycle(1, 0, 0, 0);

        // Change to 6 at cycle 10 of a bit
        wait_phase(1, 10);
        cycle(1, 0, 1, 6);
        repeat (300) cycle(1, 0, 0, 0);

        // Illegal divisors
        cycle(1, 0, 1, 1);
        repeat (20) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        repeat (120) cycle(1, 0, 0, 0);

        // Back to 4, resync at cc=2
        cycle(1, 0, 1, 4);
        repeat (200) cycle(1, 0, 0, 0);
        wait_phase(0, 2);
        cycle(1, 1, 0, 0);
        repeat (100) cycle(1, 0, 0, 0);

        // Resync on a would-be bit tick while an update is pending
        cycle(1, 0, 1, 5);
        wait_phase(1, OS * 4 - 1);
        cycle(1, 1, 0, 0);
        repeat (250) cycle(1, 0, 0, 0);

        // Disable with an update pending
        cycle(1, 0, 1, 7);
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        repeat (150) cycle(1, 0, 0, 0);

        // Randomized traffic
        en_r = 1;
        for (int n = 0; n < 20000; n++) begin
            bit rs, v;
            int d;
            if ($urandom_range(0, 499) == 0) en_r = !en_r;
            rs = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 99) == 0);
            d  = int'($urandom_range(0, 9));
            cycle(en_r, rs, v, d);
        end

        // Asynchronous reset mid-bit
        repeat (50) cycle(1, 0, 0, 0);
        @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        q.delete();
        #1;
        check("arst_tick",  int'(o_tick), 0);
        check("arst_bit",   int'(o_bit_tick), 0);
        check("arst_err",   int'(o_cfg_err), 0);
        check("arst_ready", int'(o_cfg_ready), 1);
        check("arst_div",   int'(o_div), DEF);
        repeat (2) @(posedge clk);
        #1;
        i_enable = 1'b0; i_resync = 1'b0; i_cfg_valid = 1'b0; i_cfg_div = '0;
        i_rst_n = 1'b1;
        model_reset();
        repeat (5) cycle(0, 0, 0, 0);
        repeat (400) cycle(1, 0, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Runtime-programmable baud tick controller for the UART. It generates the oversampling tick that feeds the RX/TX shift logic and a derived once-per-bit tick. It accepts new divisor values over a valid/ready handshake and applies them only on a bit boundary, so a frame in flight is never corrupted. It also supports a phase resync so RX can align the sample grid to a detected start-bit edge.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- DEFAULT_BAUD, 19200, baud rate in effect after reset
- OVERSAMPLING, 16, oversampling ticks per bit; ≥2
- NB_DIV, 16, divisor width
- clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  level; 1 = generate ticks, 0 = stopped and counters cleared
- i_cfg_valid  in  1  new divisor offered
- i_cfg_div  in  NB_DIV  clock cycles per oversampling tick
- o_cfg_ready  out  1  controller can accept a divisor
- o_cfg_err  out  1  one-cycle pulse: the accepted divisor was illegal and has been dropped
- i_resync  in  1  one-cycle pulse: restart the tick and bit phase
- o_tick  out  1  oversampling tick, one cycle wide
- o_bit_tick  out  1  bit tick, one cycle wide, coincident with an o_tick
- o_div  out  NB_DIV  divisor currently in effect

## Operation
- Registers:
  - active divisor `div`, reset value CLK_FREQ/DEFAULT_BAUD/OVERSAMPLING with integer truncation; 162 for the defaults.
  - shadow divisor `shd`.
  - cycle counter `cc`, range 0..div-1.
  - oversample counter `oc`, range 0..OVERSAMPLING-1.
- FSM states: OFF, RUN, PEND. Reset state is OFF.
- OFF:
  - `cc` and `oc` are held at 0; no ticks.
  - i_enable=1 moves to RUN with counters at 0.
- RUN:
  - `cc` increments each cycle and wraps at div-1.
  - On each wrap `oc` increments, wrapping at OVERSAMPLING-1.
  - i_enable=0 moves to OFF.
- PEND: counts exactly as RUN, with an update waiting in `shd`.
- o_tick = (state≠OFF) && cc==div-1.
- o_bit_tick = o_tick && oc==OVERSAMPLING-1.
- Handshake:
  - o_cfg_ready = (state≠PEND).
  - A transfer occurs on a cycle with i_cfg_valid && o_cfg_ready.
- Legality check on accept:
  - i_cfg_div < 2 is illegal. o_cfg_err pulses the next cycle; `div`, `shd` and state are unchanged.
- Applying an accepted legal divisor:
  - In OFF: `div` <= i_cfg_div next cycle.
  - In RUN: `shd` <= i_cfg_div and the FSM moves to PEND.
- PEND to RUN happens on a cycle with o_bit_tick=1. The next cycle has div=shd, cc=0, oc=0.
- i_resync=1 in RUN or PEND:
  - `cc` and `oc` are 0 next cycle.
  - o_tick and o_bit_tick are suppressed in the resync cycle.
  - State is unchanged; in PEND the update stays pending.
- i_resync in OFF is ignored.
- i_enable=0 in PEND: the next cycle is OFF with div=shd. A pending update is never lost.
- o_div = `div`.

## Timing
- Reset values:
  - o_tick=0, o_bit_tick=0, o_cfg_err=0.
  - o_cfg_ready=1.
  - o_div = default divisor.
- Enable:
  - i_enable is sampled at a clock edge; the following cycle is the first RUN cycle, with cc=0.
  - The first o_tick is in RUN cycle div, i.e. div cycles after entry.
  - The first o_bit_tick is in RUN cycle OVERSAMPLING*div.
- Steady-state period: o_tick every div cycles, o_bit_tick every OVERSAMPLING*div cycles.
- Config:
  - o_cfg_err and the OFF-state update of `div` both appear 1 cycle after the accept edge.
  - The RUN-state update is applied on the first o_bit_tick at or after the accept cycle + 1.
  - o_cfg_ready returns to 1 in the cycle after that bit tick.
- Priorities, highest first: asynchronous reset > i_enable=0 > i_resync > tick/wrap/update.
  - Resync on a would-be bit-tick cycle in PEND: no tick, update still pending.
- Enable dropped mid-bit: ticks stop the next cycle. No partial-bit tick is emitted.
- Counters are sized for NB_DIV and clogb2(OVERSAMPLING). No overflow at div = 2^NB_DIV − 1.

## Test plan
- **Reset, then enable with default parameters.** Expect o_div=162, first o_tick 162 cycles after RUN entry, o_bit_tick every 2592 cycles.
- **Divisor load in OFF.** In OFF write div=4, then enable. Expect o_tick every 4 cycles and o_bit_tick every 64 cycles.
- **Divisor change while running.** Running at div=4, write div=6 at cycle 10 of a bit. Expect o_cfg_ready=0 until the bit tick at cycle 63 of that bit. From the next cycle, o_tick every 6 cycles, o_bit_tick every 96, o_div=6.
- **Illegal divisors.** Write div=1, then div=0. Expect an o_cfg_err pulse 1 cycle after each accept, o_div unchanged, tick period unchanged.
- **Resync.**
  - At div=4, pulse i_resync at cc=2: expect the next o_tick exactly 4 cycles after the resync cycle, and oc restarted.
  - Pulse i_resync on a would-be bit-tick cycle in PEND: expect no tick that cycle and the update still pending.
- **Disable with update pending, and reset mid-run.**
  - Drop i_enable while in PEND: expect OFF the next cycle, o_div=shd, ticks low.
  - Assert i_rst_n=0 asynchronously mid-bit: expect outputs at their reset values immediately.
